// File: rtl/wfg_core_sync_gen.sv
// Timing generator for the waveform-generator core.
// Produces the subcycle strobe and the sync strobe from the register block's
// CTRL.EN, CFG.SUBCYCLE and CFG.SYNC. The period configuration is shadowed and
// reloaded only on a sync wrap, so every period runs to completion untruncated.
//
// Ports:
//   wb_clk_i            system clock, rising edge
//   wb_rst_i            synchronous active-high reset
//   ctrl_en_q_i         generator enable (CTRL.EN)
//   cfg_subcycle_q_i    subcycle period minus one, in clocks (CFG.SUBCYCLE)
//   cfg_sync_q_i        sync period minus one, in subcycles (CFG.SYNC)
//   wfg_subcycle_o      one-clock strobe at the end of each subcycle
//   wfg_sync_o          one-clock strobe at the end of each sync period
//   wfg_subcycle_cnt_o  subcycles completed in the current sync period
//   active_o            high while the generator is running
module wfg_core_sync_gen (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ctrl_en_q_i,
  input  logic [15:0] cfg_subcycle_q_i,
  input  logic [7:0]  cfg_sync_q_i,
  output logic        wfg_subcycle_o,
  output logic        wfg_sync_o,
  output logic [7:0]  wfg_subcycle_cnt_o,
  output logic        active_o
);

  localparam int unsigned SubW  = 16;
  localparam int unsigned SyncW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SubW-1:0]  sub_cnt_q, sub_cnt_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic [SubW-1:0]  sub_shd_q, sub_shd_d;
  logic [SyncW-1:0] sync_shd_q, sync_shd_d;
  logic             subcycle_q, subcycle_d;
  logic             sync_q, sync_d;

  // State and datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      sub_cnt_q  <= '0;
      sync_cnt_q <= '0;
      sub_shd_q  <= '0;
      sync_shd_q <= '0;
      subcycle_q <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_cnt_q  <= sub_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      sub_shd_q  <= sub_shd_d;
      sync_shd_q <= sync_shd_d;
      subcycle_q <= subcycle_d;
      sync_q     <= sync_d;
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d    = state_q;
    sub_cnt_d  = '0;
    sync_cnt_d = '0;
    sub_shd_d  = sub_shd_q;
    sync_shd_d = sync_shd_q;
    subcycle_d = 1'b0;
    sync_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_en_q_i) begin
          state_d    = RUN;
          sub_shd_d  = cfg_subcycle_q_i;
          sync_shd_d = cfg_sync_q_i;
        end
      end
      RUN: begin
        // Disable takes priority over any wrap on the same edge.
        if (!ctrl_en_q_i) begin
          state_d = IDLE;
        end else if (sub_cnt_q != sub_shd_q) begin
          sub_cnt_d  = sub_cnt_q + SubW'(1);
          sync_cnt_d = sync_cnt_q;
        end else begin
          subcycle_d = 1'b1;
          if (sync_cnt_q != sync_shd_q) begin
            sync_cnt_d = sync_cnt_q + SyncW'(1);
          end else begin
            // Sync wrap: the only point where new configuration is accepted.
            sync_d     = 1'b1;
            sub_shd_d  = cfg_subcycle_q_i;
            sync_shd_d = cfg_sync_q_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wfg_subcycle_o     = subcycle_q;
  assign wfg_sync_o         = sync_q;
  assign wfg_subcycle_cnt_o = sync_cnt_q;
  assign active_o           = (state_q == RUN);

endmodule

// File: tb/tb_wfg_core_sync_gen.sv
module tb_wfg_core_sync_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cfg_sub;
  logic [7:0]  cfg_sync;
  logic        sub_o, sync_o, act_o;
  logic [7:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: time elapsed within the current sync period.
  bit m_run;
  int m_t, m_s, m_y, m_cnt;
  bit m_sub, m_syn;

  always #5 clk = ~clk;

  wfg_core_sync_gen dut (
    .wb_clk_i           (clk),
    .wb_rst_i           (rst),
    .ctrl_en_q_i        (en),
    .cfg_subcycle_q_i   (cfg_sub),
    .cfg_sync_q_i       (cfg_sync),
    .wfg_subcycle_o     (sub_o),
    .wfg_sync_o         (sync_o),
    .wfg_subcycle_cnt_o (cnt_o),
    .active_o           (act_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_sub = 0; m_syn = 0; m_cnt = 0; m_t = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_t = 0; m_s = int'(cfg_sub); m_y = int'(cfg_sync);
      end
      m_sub = 0; m_syn = 0; m_cnt = 0;
    end else if (!en) begin
      m_run = 0; m_sub = 0; m_syn = 0; m_cnt = 0;
    end else begin
      m_t++;
      m_sub = (m_t % (m_s + 1)) == 0;
      m_syn = (m_t == (m_s + 1) * (m_y + 1));
      m_cnt = (m_t / (m_s + 1)) % (m_y + 1);
      if (m_syn) begin
        m_t = 0; m_s = int'(cfg_sub); m_y = int'(cfg_sync);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_subcycle", int'(sub_o), int'(m_sub));
    check("model_sync", int'(sync_o), int'(m_syn));
    check("model_cnt", int'(cnt_o), m_cnt);
    check("model_active", int'(act_o), int'(m_run));
  endtask

  initial begin
    int r;
    m_run = 0; m_t = 0; m_s = 0; m_y = 0; m_cnt = 0; m_sub = 0; m_syn = 0;
    rst = 1'b1; en = 1'b1; cfg_sub = 16'd3; cfg_sync = 8'd1;

    // Reset held with enable high.
    repeat (3) tick();
    check("rst_active", int'(act_o), 0);
    check("rst_sub", int'(sub_o), 0);
    rst = 1'b0;
    tick();  // E0
    check("e0_active", int'(act_o), 1);

    // S=3, Y=1 basic sequence.
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("s3_sub_e%0d", k), int'(sub_o), int'(k % 4 == 0));
      check($sformatf("s3_sync_e%0d", k), int'(sync_o), int'(k % 8 == 0));
      if (k == 3) check("s3_cnt_e3", int'(cnt_o), 0);
      if (k == 4) check("s3_cnt_e4", int'(cnt_o), 1);
      if (k == 8) check("s3_cnt_e8", int'(cnt_o), 0);
      if (k == 12) check("s3_cnt_e12", int'(cnt_o), 1);
    end
    en = 1'b0;
    tick();
    check("s3_off_active", int'(act_o), 0);

    // S=0, Y=0: strobes every clock, then disable at E5.
    cfg_sub = 16'd0; cfg_sync = 8'd0; en = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("s0_sub_e%0d", k), int'(sub_o), 1);
      check($sformatf("s0_sync_e%0d", k), int'(sync_o), 1);
    end
    en = 1'b0;
    tick();  // E5
    check("s0_off_sub", int'(sub_o), 0);
    check("s0_off_sync", int'(sync_o), 0);

    // Config write mid-period applies after the next sync wrap.
    cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
    tick();  // E0
    tick(); tick();
    cfg_sub = 16'd1;
    for (int k = 3; k <= 12; k++) begin
      tick();
      check($sformatf("cw_sub_e%0d", k), int'(sub_o),
            int'(k == 4 || k == 8 || k == 10 || k == 12));
      check($sformatf("cw_sync_e%0d", k), int'(sync_o), int'(k == 8 || k == 12));
    end
    en = 1'b0;
    tick();

    // Disable landing on a wrap edge, then re-enable at E10.
    cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
    tick();  // E0
    repeat (3) tick();
    en = 1'b0;
    tick();  // E4
    check("dw_sub", int'(sub_o), 0);
    check("dw_active", int'(act_o), 0);
    repeat (5) tick();
    en = 1'b1;
    tick();  // new E0
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("re_sub_e%0d", k), int'(sub_o), int'(k == 4));
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_active", int'(act_o), 0);
    check("mid_rst_cnt", int'(cnt_o), 0);
    check("mid_rst_sub", int'(sub_o), 0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      rst = (r < 2);
      if (r >= 2 && r < 6) en = ~en;
      if (r >= 6 && r < 14) cfg_sub = 16'($urandom_range(0, 5));
      if (r >= 14 && r < 22) cfg_sync = 8'($urandom_range(0, 3));
      if (r >= 22 && r < 26) en = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfg_core_sync_gen.md
# wfg_core_sync_gen

Timing generator of the waveform-generator core. It consumes the enable and cycle configuration held by the core's Wishbone register block (CTRL.EN, CFG.SUBCYCLE, CFG.SYNC). From these it produces the subcycle strobe and the sync strobe that pace every downstream waveform stimulus and driver. Configuration is shadowed and takes effect only at sync boundaries, so software writes never produce a truncated or glitched period.

## Interface
- No parameters; widths are fixed by the register map.
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- ctrl_en_q_i  in  1  CTRL.EN; high = generator running.
- cfg_subcycle_q_i  in  16  CFG.SUBCYCLE; subcycle period = value+1 clocks.
- cfg_sync_q_i  in  8  CFG.SYNC; sync period = value+1 subcycles.
- wfg_subcycle_o  out  1  registered one-clock strobe at end of each subcycle.
- wfg_sync_o  out  1  registered one-clock strobe at end of each sync period; always coincides with wfg_subcycle_o.
- wfg_subcycle_cnt_o  out  8  subcycles completed in the current sync period.
- active_o  out  1  high while in RUN.

## Operation
- Registers:
  - state: IDLE/RUN.
  - sub_cnt: 16 b.
  - sync_cnt: 8 b.
  - sub_shd: 16 b shadow of CFG.SUBCYCLE.
  - sync_shd: 8 b shadow of CFG.SYNC.
  - both strobe flops.
- Reset: state=IDLE and every register and output is 0.
- IDLE:
  - Counters and strobes held at 0.
  - On an edge where ctrl_en_q_i=1: state→RUN, sub_shd←cfg_subcycle_q_i, sync_shd←cfg_sync_q_i, sub_cnt←0, sync_cnt←0.
- RUN, ctrl_en_q_i=1, each edge:
  - sub_cnt≠sub_shd: sub_cnt+1; wfg_subcycle_o←0; wfg_sync_o←0.
  - sub_cnt=sub_shd (subcycle wrap): sub_cnt←0; wfg_subcycle_o←1.
    - sync_cnt≠sync_shd: sync_cnt+1; wfg_sync_o←0.
    - sync_cnt=sync_shd (sync wrap): sync_cnt←0; wfg_sync_o←1; reload sub_shd and sync_shd from the current inputs.
- RUN, ctrl_en_q_i=0 on an edge: state→IDLE; counters and strobes←0. Disable wins over a simultaneous wrap, so no strobe is issued on that edge.
- Config writes during RUN do not affect the current sync period. The new values apply from the first clock after the next sync wrap.
- wfg_subcycle_cnt_o=sync_cnt; active_o=(state==RUN).
- Arithmetic is unsigned. Counters never exceed their shadow, so overflow cannot occur.
  - CFG.SUBCYCLE=0: subcycle strobe every clock.
  - CFG.SYNC=0: sync strobe on every subcycle strobe.
  - Both 0: both strobes constantly high while running.
- Re-enable after disable always starts a fresh period with freshly loaded shadows.

## Timing
- Edge numbering: E0 = first edge sampling ctrl_en_q_i=1 in IDLE. "After Ek" = value in the cycle following edge k.
- Let S=sub_shd and Y=sync_shd.
- active_o is high after E0.
- wfg_subcycle_o is high after E(S+1), E2(S+1), …, each for exactly one clock.
- wfg_sync_o is high after E(Y+1)(S+1), then every (Y+1)(S+1) clocks.
- Disable sampled at edge Ed: all outputs are 0 after Ed.
- wb_rst_i asserted mid-operation: all outputs are 0 after that edge, regardless of ctrl_en_q_i. If ctrl_en_q_i is high at the first edge with wb_rst_i low, that edge is E0.

## Test plan
- Reset with ctrl_en_q_i=1 throughout: all outputs 0 while reset is asserted; active_o=1 after the first edge following release.
- S=3, Y=1, enable:
  - wfg_subcycle_o high after E4, E8, E12, E16.
  - wfg_sync_o high only after E8 and E16.
  - wfg_subcycle_cnt_o = 0,1,0,1 after E3, E4, E8, E12.
- S=0, Y=0: both strobes high every clock from after E1. Drop enable at E5: both strobes 0 after E5.
- S=3, Y=1 running; write CFG.SUBCYCLE=1 after E2:
  - Subcycle strobes stay at E4 and E8.
  - After the sync wrap at E8, strobes follow at E10, E12; next sync strobe after E12.
- Disable on a wrap edge: with S=3, deassert so that E4 samples 0. No strobe after E4; active_o=0.
- Re-enable at E10 (new E0): first strobe after E4 relative to the new E0. Assert wb_rst_i mid-period: all outputs 0 on the following cycle.
